// File: rtl/mic_volume_meter_if.sv
// Sample-in / level-out bundle for mic_volume_meter.
// master: the sample source that reads the meter results.
// slave:  the meter itself.
interface mic_volume_meter_if;
  logic        sample_valid;
  logic [11:0] mic_in;
  logic [10:0] peak_mag;
  logic [3:0]  level_raw;
  logic [3:0]  level_peak;
  logic        level_valid;

  modport master (
    output sample_valid, mic_in,
    input  peak_mag, level_raw, level_peak, level_valid
  );

  modport slave (
    input  sample_valid, mic_in,
    output peak_mag, level_raw, level_peak, level_valid
  );
endinterface

// File: rtl/mic_volume_meter.sv
// mic_volume_meter: windowed peak magnitude and 4-bit volume levels from a
// 12-bit offset-binary mic stream (2048 = silence).
//   stage 1 : |mic_in - 2048|, saturated to 11 bits, noise-floor gated
//   stage 2 : running max over WINDOW accepted samples; the closing sample
//             updates peak_mag / level_raw / level_peak directly, so
//             level_valid lands 2 cycles after the closing strobe.
// Optional feature macro: VOLUME_METER_HOLD_EN
//   defined   -> level_peak holds for HOLD_WINDOWS windows, then decays by 1
//   undefined -> level_peak simply mirrors level_raw, hold counter removed
module mic_volume_meter #(
  parameter int unsigned WINDOW       = 4000,
  parameter int unsigned NOISE_FLOOR  = 64,
  parameter int unsigned HOLD_WINDOWS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  mic_volume_meter_if.slave bus
);

  // Out-of-range parameters are rejected at elaboration.
  if (WINDOW < 2 || WINDOW > 65535 || HOLD_WINDOWS < 1 || HOLD_WINDOWS > 15) begin : g_bad_param
    $error("mic_volume_meter: WINDOW or HOLD_WINDOWS out of range");
  end

  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
  // Magnitudes never exceed 2048 before saturation, so clamp the floor there.
  localparam logic [11:0] FLOOR    = (NOISE_FLOOR > 2048) ? 12'd2048 : 12'(NOISE_FLOOR);
  localparam logic [11:0] MIDSCALE = 12'd2048;

  // ---------------------------------------------------------------------
  // Stage 1: magnitude
  // ---------------------------------------------------------------------
  logic [11:0] diff;
  logic [10:0] mag_new;
  logic [10:0] mag_q, mag_d;
  logic        mag_v_q;

  // Absolute distance from mid-scale, 2048 saturated to 2047, floor gated.
  always_comb begin
    diff    = '0;
    mag_new = '0;
    if (bus.mic_in >= MIDSCALE) diff = bus.mic_in - MIDSCALE;
    else                        diff = MIDSCALE - bus.mic_in;
    mag_new = diff[11] ? 11'h7FF : diff[10:0];
    if (diff < FLOOR) mag_new = '0;
  end

  // Magnitude only loads on a strobe; idle cycles leave it alone.
  always_comb begin
    mag_d = mag_q;
    if (bus.sample_valid) mag_d = mag_new;
  end

  // Stage-1 pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q   <= '0;
      mag_v_q <= 1'b0;
    end else begin
      mag_q   <= mag_d;
      mag_v_q <= bus.sample_valid;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: window accumulation and result update
  // ---------------------------------------------------------------------
  logic [10:0] run_max_q, run_max_d;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [10:0] final_max;
  logic        win_end;
  logic [3:0]  lvl_new;

  logic [10:0] peak_mag_q,    peak_mag_d;
  logic [3:0]  level_raw_q,   level_raw_d;
  logic [3:0]  level_peak_q,  level_peak_d;
  logic        level_valid_q, level_valid_d;

  // Max including the current sample, so the closing sample counts.
  always_comb begin
    final_max = (mag_q > run_max_q) ? mag_q : run_max_q;
    win_end   = mag_v_q && (win_cnt_q == WIN_LAST);
    lvl_new   = final_max[10:7];
  end

  // Running max / sample counter; both restart after the closing sample.
  always_comb begin
    run_max_d = run_max_q;
    win_cnt_d = win_cnt_q;
    if (mag_v_q) begin
      if (win_end) begin
        run_max_d = '0;
        win_cnt_d = '0;
      end else begin
        run_max_d = final_max;
        win_cnt_d = win_cnt_q + 16'd1;
      end
    end
  end

`ifdef VOLUME_METER_HOLD_EN
  localparam logic [3:0] HOLD_MAX = 4'(HOLD_WINDOWS);

  logic [3:0] hold_cnt_q, hold_cnt_d;

  // Peak-hold: a new level >= the held one refreshes it; otherwise count
  // windows up to HOLD_MAX, then step down one level per window. The
  // counter stays saturated while decaying, and a lower-but-nonzero window
  // does not restart it.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    level_peak_d = level_peak_q;
    if (win_end) begin
      if (lvl_new >= level_peak_q) begin
        level_peak_d = lvl_new;
        hold_cnt_d   = '0;
      end else if (hold_cnt_q < HOLD_MAX) begin
        hold_cnt_d   = hold_cnt_q + 4'd1;
      end else begin
        level_peak_d = level_peak_q - 4'd1;
      end
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end
`else
  // Without hold the peak level just tracks the raw level each window.
  always_comb begin
    level_peak_d = level_peak_q;
    if (win_end) level_peak_d = lvl_new;
  end
`endif

  // Result outputs load only at the window end; they hold otherwise.
  always_comb begin
    peak_mag_d    = peak_mag_q;
    level_raw_d   = level_raw_q;
    level_valid_d = win_end;
    if (win_end) begin
      peak_mag_d  = final_max;
      level_raw_d = lvl_new;
    end
  end

  // Stage-2 state and output registers; reset discards any partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max_q     <= '0;
      win_cnt_q     <= '0;
      peak_mag_q    <= '0;
      level_raw_q   <= '0;
      level_peak_q  <= '0;
      level_valid_q <= 1'b0;
    end else begin
      run_max_q     <= run_max_d;
      win_cnt_q     <= win_cnt_d;
      peak_mag_q    <= peak_mag_d;
      level_raw_q   <= level_raw_d;
      level_peak_q  <= level_peak_d;
      level_valid_q <= level_valid_d;
    end
  end

  assign bus.peak_mag    = peak_mag_q;
  assign bus.level_raw   = level_raw_q;
  assign bus.level_peak  = level_peak_q;
  assign bus.level_valid = level_valid_q;

endmodule

// File: tb/tb_mic_volume_meter.sv
// Scoreboard bench for mic_volume_meter (WINDOW=4). A behavioural model
// runs as each sample is driven and queues the expected result with the
// cycle it must appear on; a negedge monitor pops and compares.
module tb_mic_volume_meter;
  localparam int WIN   = 4;
  localparam int FLOOR = 64;
  localparam int HOLD  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  mic_volume_meter_if bus ();

  mic_volume_meter #(.WINDOW(WIN), .NOISE_FLOOR(FLOOR), .HOLD_WINDOWS(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cy;
    int pk;
    int raw;
    int lp;
  } exp_t;
  exp_t sb[$];

  // model state
  int m_cnt = 0, m_max = 0, m_lp = 0, m_hold = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int mag_of(input int v);
    int d;
    d = v - 2048;
    if (d < 0) d = -d;
    if (d > 2047) d = 2047;
    if (d < FLOOR) d = 0;
    return d;
  endfunction

  task automatic model(input int v);
    int m, raw;
    m = mag_of(v);
    if (m > m_max) m_max = m;
    m_cnt++;
    if (m_cnt == WIN) begin
      raw = m_max / 128;
`ifdef VOLUME_METER_HOLD_EN
      if (raw >= m_lp) begin
        m_lp = raw; m_hold = 0;
      end else if (m_hold < HOLD) begin
        m_hold++;
      end else begin
        m_lp--;
      end
`else
      m_lp = raw;
`endif
      sb.push_back('{cy: cyc + 2, pk: m_max, raw: raw, lp: m_lp});
      m_cnt = 0;
      m_max = 0;
    end
  endtask

  // Drive one strobe for the cycle following the current posedge.
  task automatic send(input int v);
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.mic_in       = 12'(v);
    model(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.sample_valid = 1'b0;
      bus.mic_in       = 12'(2048);
    end
  endtask

  task automatic win4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_peak_mag"},    int'(bus.peak_mag),    0);
    chk({tag, "_level_raw"},   int'(bus.level_raw),   0);
    chk({tag, "_level_peak"},  int'(bus.level_peak),  0);
    chk({tag, "_level_valid"}, int'(bus.level_valid), 0);
  endtask

  // Monitor: each level_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (bus.level_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency",    cyc,                   e.cy);
          chk("peak_mag",   int'(bus.peak_mag),    e.pk);
          chk("level_raw",  int'(bus.level_raw),   e.raw);
          chk("level_peak", int'(bus.level_peak),  e.lp);
        end
      end else if (sb.size() != 0 && sb[0].cy < cyc) begin
        chk("missing_valid", cyc, sb[0].cy);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_valid = 1'b0;
    bus.mic_in       = 12'(2048);
    #2;
    chk_zero("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // reset mid-window: 2 samples then reset; partial window discarded
    send(3000); send(3000);
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    rst_n = 1'b0;
    m_cnt = 0; m_max = 0; m_lp = 0; m_hold = 0;
    #2;
    chk_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_zero("post_rst");

    // silent full window after release
    win4(2048, 2048, 2048, 2048);
    idle(4);

    // magnitude / quantisation: 952 -> 7, 52 gated by floor
    win4(2048, 3000, 2100, 2048);
    idle(4);

    // saturation: mic_in=0 -> 2047
    win4(0, 4095, 2048, 2048);
    idle(4);

    // noise floor boundary: 64 passes, 63 gated; window counts accepted
    // samples only, so gaps do not shorten it
    send(1985); idle(2); send(2112); idle(3); send(2048); send(2048);
    idle(4);

    // back-to-back windows at full rate
    win4(3000, 2048, 2048, 2048);
    win4(2048, 2048, 2048, 2560);
    idle(4);

    // hold/decay: level 15 then silent windows
    win4(0, 2048, 2048, 2048);
    repeat (5) win4(2048, 2048, 2048, 2048);
    idle(4);

    // refresh: 15, two silent, level 10, then silence
    win4(4095, 2048, 2048, 2048);
    repeat (2) win4(2048, 2048, 2048, 2048);
    win4(3348, 2048, 2048, 2048);
    repeat (3) win4(2048, 2048, 2048, 2048);
    idle(6);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mic_volume_meter.md
# mic_volume_meter

Converts the raw 12-bit microphone sample stream from the audio capture stage into a windowed peak magnitude and 4-bit volume levels (raw and peak-hold). It sits directly downstream of the audio capture stage and upstream of the LED bar, seven-segment and game logic that consume `volume_level_raw` / `volume_level_peak`. All logic runs on the 100 MHz board clock. A one-cycle `sample_valid` strobe qualifies each sample.

## Interface
- `WINDOW`, 4000: accepted samples per measurement window (0.2 s at 20 kHz); legal range 2..65535.
- `NOISE_FLOOR`, 64: magnitudes strictly below this value are treated as 0.
- `HOLD_WINDOWS`, 3: windows the peak level is held before decay starts; legal range 1..15.
- `clk`  in  1  board clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  one-cycle strobe, synchronous to `clk`; may be high on consecutive cycles.
- `mic_in`  in  12  unsigned sample; 2048 is silence.
- `peak_mag`  out  11  maximum magnitude of the last completed window.
- `level_raw`  out  4  `peak_mag[10:7]`, registered.
- `level_peak`  out  4  peak-hold / decaying level.
- `level_valid`  out  1  one-cycle pulse when the three outputs above update.

## Operation
- Stage 1, on a cycle with `sample_valid`=1: compute `mag = |mic_in − 2048|`.
  - Saturate 2048 to 2047, so `mic_in`=0 gives 2047.
  - If `mag` < `NOISE_FLOOR`, force `mag` to 0.
  - Register `mag` and `mag_v`.
- Stage 2, on a cycle with `mag_v`=1:
  - `run_max <= max(run_max, mag)`.
  - `win_cnt` increments.
  - When `win_cnt` = `WINDOW`−1, this sample ends the window: it is included in the result, then `run_max` clears to 0 and `win_cnt` clears to 0.
- Window end, computed from the final max including the closing sample:
  - `peak_mag <= final_max`.
  - `level_raw <= final_max[10:7]`.
  - Peak-hold update:
    - If `level_raw_new` ≥ `level_peak`: `level_peak <= level_raw_new` and `hold_cnt <= 0`.
    - Else if `hold_cnt` < `HOLD_WINDOWS`: `hold_cnt` increments and `level_peak` is unchanged.
    - Else: `level_peak` decrements by 1. It never goes below `level_raw_new`, because that case is covered by the first branch. `hold_cnt` stays saturated.
  - `level_valid` pulses high for one cycle.
- Samples arriving while the window-end update is in progress are accepted normally and counted in the next window. There is no stall or back-pressure.
- `sample_valid`=0 leaves all state unchanged. The window counts accepted samples, not cycles.

## Timing
- Latency: from the `sample_valid` cycle of the closing sample to `level_valid`=1 is exactly 2 cycles. Outputs change in the same cycle as `level_valid`.
- Between window ends, outputs hold their last value.
- Reset (asynchronous, any time, including mid-window):
  - Outputs: `peak_mag`=0, `level_raw`=0, `level_peak`=0, `level_valid`=0.
  - Internal state: `run_max`, `win_cnt`, `hold_cnt` and the stage-1 registers = 0.
  - A partial window is discarded, and the first window after release is a full `WINDOW` samples.
- Back-to-back strobes at full clock rate are supported: one sample per cycle with no loss.

## Configuration
- `VOLUME_METER_HOLD_EN` defined: peak-hold/decay logic and `hold_cnt` are compiled in, as described above.
- Not defined: `hold_cnt` is removed. `level_peak` is assigned `level_raw` at every window end, so both update together and have identical values.

## Test plan
- Reset / idle (`WINDOW`=4): assert `rst_n`=0 mid-window after 2 samples, then release. All outputs read 0. Send 4 samples of 2048: `level_valid` pulses 2 cycles after the 4th strobe, with `peak_mag`=0 and `level_raw`=0.
- Magnitude and quantisation (`WINDOW`=4): samples 2048, 3000, 2100, 2048.
  - Result: `peak_mag`=952, `level_raw`=7.
  - 2100 (mag 52) is below the noise floor and does not contribute.
- Saturation (`WINDOW`=4): samples 0, 4095, 2048, 2048. Result: `peak_mag`=2047, `level_raw`=15.
- Back-to-back windows (`WINDOW`=4): 8 consecutive-cycle strobes.
  - Sample values: 3000, 2048, 2048, 2048, 2048, 2048, 2048, 2560.
  - Two `level_valid` pulses, 4 cycles apart.
  - First pulse: `peak_mag`=952. Second pulse: `peak_mag`=512 (the first window's max does not carry over), `level_raw`=4.
- Hold/decay (`VOLUME_METER_HOLD_EN`, `HOLD_WINDOWS`=3): one window at level 15, then silent windows.
  - `level_peak` sequence over successive windows: 15, 15, 15, 15, 14, 13 …
  - Without the macro: `level_peak` sequence is 15, 0, 0 …
- Peak refresh (hold enabled): a level-15 window, 2 silent windows, then a level-10 window.
  - `level_peak` stays 15 through the level-10 window.
  - `hold_cnt` keeps counting and is not reset.
  - Decay then continues from 15.
